// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial stimulus stage: captures a WIDTH-bit pattern on start and
// shifts it out one bit per clock into the detector's X input, optionally looping.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  localparam int IW       = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [IW-1:0]    bit_idx,
  output logic [1:0]       dbg_state
);

  // x_valid has no ready partner: the detector samples x_out on every rising
  // edge, so a bit is consumed in the cycle it is presented and never held back.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] shreg;

  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  // shreg keeps the bits still to be sent, next one at the shift-out end.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      pattern <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      x_out   <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          bit_idx <= '0;
          if (start && !stop) begin
            pattern <= data_in;
            shreg   <= advance(data_in);
            x_out   <= first_bit(data_in);
            x_valid <= 1'b1;
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            x_out   <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
          end
        end

        SHIFT: begin
          if (stop) begin
            state   <= IDLE;
            x_out   <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_idx <= '0;
          end else if (bit_idx == LAST_IDX) begin
            if (loop_en) begin
              // Back-to-back repetition: bit 0 follows the last bit directly.
              shreg   <= advance(pattern);
              x_out   <= first_bit(pattern);
              x_valid <= 1'b1;
              bit_idx <= '0;
            end else begin
              state   <= DONE;
              x_out   <= 1'b0;
              x_valid <= 1'b0;
              done    <= 1'b1;
              bit_idx <= '0;
            end
          end else begin
            shreg   <= advance(shreg);
            x_out   <= first_bit(shreg);
            x_valid <= 1'b1;
            bit_idx <= bit_idx + IW'(1);
          end
        end

        DONE: begin
          state   <= IDLE;
          x_out   <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          bit_idx <= '0;
        end

        default: begin
          state   <= IDLE;
          x_out   <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: an MSB-first and an LSB-first instance share
// stimulus; per-cycle expected output tuples come from the serialization rules.
module tb_seq_bit_serializer;

  localparam int WIDTH = 8;
  localparam int W     = 14;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             loop_en;
  logic [WIDTH-1:0] data_in;

  logic       xo_m, xv_m, busy_m, done_m;
  logic [2:0] idx_m;
  logic [1:0] st_m;
  logic       xo_l, xv_l, busy_l, done_l;
  logic [2:0] idx_l;
  logic [1:0] st_l;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  seq_bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .data_in(data_in), .x_out(xo_m), .x_valid(xv_m), .busy(busy_m),
    .done(done_m), .bit_idx(idx_m), .dbg_state(st_m)
  );

  seq_bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .data_in(data_in), .x_out(xo_l), .x_valid(xv_l), .busy(busy_l),
    .done(done_l), .bit_idx(idx_l), .dbg_state(st_l)
  );

  // clock / reset
  always #5 clk = ~clk;

  // expected tuple: {busy, done, x_valid, x_out} per instance, then both bit indices
  function automatic logic [W-1:0] mk(input logic b, input logic d, input logic v,
                                      input logic om, input logic ol, input int k);
    logic [2:0] kk;
    kk = 3'(k);
    return {b, d, v, om, b, d, v, ol, kk, kk};
  endfunction

  // reference: bit k of a run is p[WIDTH-1-k] MSB-first and p[k] LSB-first
  task automatic push_bits(input logic [WIDTH-1:0] p, input int from, input int to);
    for (int k = from; k <= to; k++)
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, p[WIDTH-1-k], p[k], k));
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
  endtask

  task automatic push_run(input logic [WIDTH-1:0] p, input int reps);
    for (int r = 0; r < reps; r++) push_bits(p, 0, WIDTH-1);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    push_idle(1);
  endtask

  // driver + scoreboard: advance one clock, sample 1 ns later, compare to queue head
  task automatic step_check(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] expv;
    @(posedge clk);
    #1;
    obs = {busy_m, done_m, xv_m, xo_m, busy_l, done_l, xv_l, xo_l, idx_m, idx_l};
    n_checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // one run: start pulse, optional stray start/data noise while busy,
  // loop_en held until the first bit of the final repetition
  task automatic do_run(input string tag, input logic [WIDTH-1:0] p,
                        input int reps, input bit noise);
    int total;
    total   = WIDTH * reps + 2;
    push_run(p, reps);
    start   = 1'b1;
    data_in = p;
    loop_en = (reps > 1);
    for (int c = 1; c <= total; c++) begin
      step_check(tag);
      start = 1'b0;
      if (c >= WIDTH * (reps - 1) + 1) loop_en = 1'b0;
      if (noise && c < total) begin
        start   = 1'($urandom_range(0, 1));
        data_in = WIDTH'($urandom);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    data_in = '0;

    push_idle(2);
    step_check("reset");
    step_check("reset");
    reset = 1'b1;
    push_idle(1);
    step_check("idle_after_reset");

    do_run("msb_b2", 8'hB2, 1, 1'b0);
    do_run("lsb_2d", 8'h2D, 1, 1'b0);
    do_run("loop_c3", 8'hC3, 3, 1'b0);

    // start with 8'hFF during a run of 8'h00 must be ignored
    push_run(8'h00, 1);
    start = 1'b1;
    data_in = 8'h00;
    for (int c = 1; c <= WIDTH + 2; c++) begin
      step_check("start_busy");
      start = (c == 3);
      data_in = (c == 3) ? 8'hFF : 8'h00;
    end
    start = 1'b0;

    // stop during cycle 3: idle from cycle 4, no done
    push_bits(8'h5A, 0, 2);
    push_idle(2);
    start = 1'b1;
    data_in = 8'h5A;
    step_check("stop");
    start = 1'b0;
    step_check("stop");
    step_check("stop");
    stop = 1'b1;
    step_check("stop_idle");
    stop = 1'b0;
    step_check("stop_idle");

    // reset during cycle 5 of a run, then a fresh run from bit 0
    push_bits(8'hE7, 0, 4);
    push_idle(1);
    start = 1'b1;
    data_in = 8'hE7;
    for (int c = 1; c <= 5; c++) begin
      step_check("mid_reset");
      start = 1'b0;
    end
    reset = 1'b0;
    step_check("mid_reset_zero");
    reset = 1'b1;
    do_run("replay_e7", 8'hE7, 1, 1'b0);

    // start and stop together in IDLE
    push_idle(3);
    start = 1'b1;
    stop = 1'b1;
    data_in = 8'hFF;
    for (int i = 0; i < 3; i++) step_check("start_stop_idle");
    start = 1'b0;
    stop = 1'b0;

    // randomized runs with stray requests while busy
    for (int r = 0; r < 12; r++) begin
      do_run("rand_run", WIDTH'($urandom), $urandom_range(1, 3), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        push_idle(1);
        step_check("rand_gap");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Parallel-to-serial stimulus stage that drives the single-bit `X` input of the two-flip-flop sequential detector stage. It captures a WIDTH-bit pattern on a start request and shifts it out one bit per clock, MSB- or LSB-first. It can repeat the pattern continuously, and it signals completion with a one-cycle done pulse. It shares the detector's clock and reset, so the detector samples one serialized bit per rising edge.

## Interface
- `WIDTH`, default 8: pattern length in bits; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 = shift `data_in[WIDTH-1]` first; 0 = shift `data_in[0]` first.
- `clk`  input  1  rising-edge clock, common with the downstream detector.
- `reset`  input  1  reset, synchronous, active-low.
- `start`  input  1  request to load `data_in` and begin shifting; honoured only in IDLE.
- `stop`  input  1  abort request; ends shifting after the current edge.
- `loop_en`  input  1  1 = reload the captured pattern after the last bit and continue without a gap.
- `data_in`  input  WIDTH  pattern to serialize; sampled only on the edge that accepts `start`.
- `x_out`  output  1  serial bit; feeds the detector's `X` input.
- `x_valid`  output  1  high while `x_out` carries a pattern bit.
- `busy`  output  1  high in SHIFT and DONE.
- `done`  output  1  one-cycle pulse after the final bit of a non-looping run.
- `bit_idx`  output  $clog2(WIDTH)  index of the bit currently on `x_out`; 0 = first bit sent.

## Operation
- All outputs are registered.
- **Registers:**
  - `pattern`: holds the captured copy of `data_in`.
  - `shreg`: working shift register.
  - `bit_idx`: counter.
  - 2-bit state register.
- **States:** IDLE, SHIFT, DONE.
- **Reset** (`reset`==0 at a rising edge): state=IDLE, `x_out`=0, `x_valid`=0, `busy`=0, `done`=0, `bit_idx`=0, `shreg`=0, `pattern`=0. Reset overrides every other input in any state, including mid-run.
- **IDLE:**
  - `start`=1 and `stop`=0: capture `data_in` into `pattern` and `shreg`, then go to SHIFT.
  - `stop`=1: `start` is ignored and the block stays in IDLE.
- **SHIFT:** on each edge, present the next bit (order set by `MSB_FIRST`) and increment `bit_idx`.
- **Last bit** (`bit_idx`==WIDTH-1); `loop_en` is sampled on this edge:
  - `loop_en`=1: reload `shreg` from `pattern`, set `bit_idx` to 0, and stay in SHIFT. There is no idle cycle between repetitions.
  - `loop_en`=0: go to DONE.
- **`stop`=1 in SHIFT:** go to IDLE on that edge. `x_valid` drops next cycle and `done` is not asserted. Priority order is `reset` > `stop` > `loop_en`.
- **DONE:** lasts exactly one cycle with `done`=1, `x_valid`=0 and `busy`=1, then goes to IDLE.
- **`start` while busy:** ignored in SHIFT and DONE; `data_in` changes are also ignored. A new run needs `start` while in IDLE.
- **`x_out` when not valid:** forced to 0 whenever `x_valid`=0, so the detector sees X=0 between runs.
- **`bit_idx` in IDLE and DONE:** held at 0.

## Timing
- `start` accepted at edge T0, then:
  - T1: `x_valid`=1, first bit on `x_out`, `bit_idx`=0.
  - Tk: bit k-1 is on `x_out`; each bit is stable for exactly one clock period.
  - TWIDTH: last bit, `bit_idx`=WIDTH-1.
  - TWIDTH+1: DONE, `done`=1, `x_valid`=0, `x_out`=0.
  - TWIDTH+2: IDLE, `busy`=0. The earliest next accept is the edge at TWIDTH+2.
- Latency from `start` to the first bit is 1 cycle. A non-looping run occupies WIDTH+2 cycles from accept to IDLE.
- With `loop_en` held at 1, bits are continuous with period WIDTH, and bit 0 of the next repetition appears at TWIDTH+1.
- `stop` asserted at edge Ts: IDLE and `x_valid`=0 from Ts+1 onward.
- `reset` asserted at edge Tr: all outputs take their reset values from Tr+1 onward, whatever the state.
- The detector samples `x_out` on the same rising edge that advances it. No combinational path exists from any input to any output.

## Test plan
- **MSB-first run:** WIDTH=8, MSB_FIRST=1, `data_in`=8'b1011_0010, one-cycle `start` -> `x_out`=1,0,1,1,0,0,1,0 on cycles 1–8 with `x_valid`=1; `done`=1 on cycle 9 only; `busy`=0 from cycle 10.
- **LSB-first run:** MSB_FIRST=0, `data_in`=8'h2D -> `x_out`=1,0,1,1,0,1,0,0 on cycles 1–8; `bit_idx` counts 0..7.
- **Looping:** `loop_en`=1, `data_in`=8'hC3 -> the sequence 1,1,0,0,0,0,1,1 repeats gap-free for 3 repetitions (24 cycles) and `done` never asserts. Drop `loop_en` during the third repetition -> DONE follows its last bit.
- **Start while busy:** pulse `start` with `data_in`=8'hFF on cycle 4 of a run of 8'h00 -> the output stays all-zero for 8 bits, and exactly one `done` occurs.
- **Abort and reset mid-run:**
  - `stop` on cycle 3 -> `x_valid`=0 from cycle 4 and no `done`.
  - `reset`=0 on cycle 5 of a new run -> every output is 0 on cycle 6.
  - A fresh `start` then replays correctly from bit 0.
- **Priority:** `start`=1 and `stop`=1 together in IDLE -> remains IDLE and `x_valid` stays 0.
